// File: rtl/fp8_result_decoder_if.sv
// fp8_result_decoder_if
//   Handshake bundle for fp8_result_decoder.
//   in_*  : FP8 E4M3 byte in (valid/ready), driven by the producer.
//   out_* : signed fixed-point result out (valid/ready), driven by the decoder.
//   Optional: FP8_NAN_FLAG_EN adds out_nan alongside out_data.
//   modport slave  : decoder side.
//   modport master : producer/consumer side (bench, datapath).
interface fp8_result_decoder_if #(
  parameter int OUT_W = 16
);
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_ovf;
  logic             out_valid;
  logic             out_ready;
`ifdef FP8_NAN_FLAG_EN
  logic             out_nan;
`endif

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ovf, out_valid
`ifdef FP8_NAN_FLAG_EN
    , output out_nan
`endif
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ovf, out_valid
`ifdef FP8_NAN_FLAG_EN
    , input out_nan
`endif
  );
endinterface

// File: rtl/fp8_result_decoder.sv
// fp8_result_decoder
//   Converts one FP8 E4M3 byte (bias 7, S.1111.111 = NaN, no inf) into a
//   signed OUT_W-bit fixed-point word with FRAC_W fraction bits, using a
//   shifter that moves the significand one bit per cycle.
// Ports:
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   ena    : enable; when low every register holds and in_ready is 0
//   bus    : fp8_result_decoder_if.slave (in_* byte handshake, out_* result)
// Optional feature macro: FP8_NAN_FLAG_EN adds bus.out_nan (1 when the
//   accepted byte was NaN), registered together with out_data.
module fp8_result_decoder #(
  parameter int OUT_W  = 16,
  parameter int FRAC_W = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic                  ena,
  fp8_result_decoder_if.slave  bus
);
  // Eight headroom bits keep the largest left shift (4-bit sig << 12) exact.
  localparam int MAG_W = OUT_W + 8;
  localparam logic [MAG_W-1:0] MAX_MAG = {{9{1'b0}}, {(OUT_W-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;

  state_t           state_q, state_d;
  logic [MAG_W-1:0] mag_q, mag_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             dir_q, dir_d;     // 1 = shift left
  logic             sign_q, sign_d;
  logic             nan_q, nan_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;

  logic             in_ready;
  logic [3:0]       exp_f;
  logic [3:0]       e_eff;
  logic [3:0]       sig;
  logic             is_nan;
  logic signed [5:0] shamt;
  logic [3:0]       shamt_abs;
  logic [OUT_W-1:0] mag_trunc;

  assign in_ready = (state_q == IDLE) && ena;

  always_comb begin
    exp_f     = bus.in_data[6:3];
    is_nan    = &bus.in_data[6:0];
    e_eff     = (exp_f == 4'd0) ? 4'd1 : exp_f;
    sig       = {(exp_f != 4'd0), bus.in_data[2:0]};
    shamt     = 6'(int'(e_eff) - 10 + FRAC_W);
    shamt_abs = shamt[5] ? 4'(-shamt) : 4'(shamt);
    mag_trunc = mag_q[OUT_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    sign_d     = sign_q;
    nan_d      = nan_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready) begin
          sign_d  = bus.in_data[7];
          nan_d   = is_nan;
          // NaN takes the s=0 path so its latency matches a normal byte.
          mag_d   = is_nan ? '0 : MAG_W'(sig);
          cnt_d   = is_nan ? '0 : shamt_abs;
          dir_d   = ~shamt[5];
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != 4'd0) begin
          mag_d = dir_q ? (mag_q << 1) : (mag_q >> 1);
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (nan_q) begin
            out_data_d = '0;
            out_ovf_d  = 1'b0;
          end else if (mag_q > MAX_MAG) begin
            out_data_d = sign_q ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
            out_ovf_d  = 1'b1;
          end else begin
            out_data_d = sign_q ? (-mag_trunc) : mag_trunc;
            out_ovf_d  = 1'b0;
          end
          state_d = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mag_q      <= '0;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      sign_q     <= 1'b0;
      nan_q      <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else if (ena) begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      sign_q     <= sign_d;
      nan_q      <= nan_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

`ifdef FP8_NAN_FLAG_EN
  logic out_nan_q, out_nan_d;

  always_comb begin
    out_nan_d = out_nan_q;
    if (state_q == SHIFT && cnt_q == 4'd0) out_nan_d = nan_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)   out_nan_q <= 1'b0;
    else if (ena) out_nan_q <= out_nan_d;
  end

  assign bus.out_nan = out_nan_q;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;
endmodule

// File: doc/fp8_result_decoder.md
Name: fp8_result_decoder

Overview:
Result-side companion to the tt_um_lightFP8 datapath. It accepts one FP8 E4M3 result byte (OCP encoding: sign[7], exp[6:3], mant[2:0], bias 7, no infinities, S.1111.111 = NaN) over a valid/ready handshake. It converts the byte to a signed two's-complement fixed-point word using a 1-bit-per-cycle iterative shifter. It presents the result over a second valid/ready handshake, so FP8 products can be read back as integers or fixed-point values for the uo_out readout path and the bench scoreboard.

Parameters:
OUT_W, 16, width of out_data (signed two's complement)
FRAC_W, 4, fractional bits in out_data; legal range 0..7

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
ena  input  1  design enable; when 0 the FSM and all registers hold their values
in_data  input  8  FP8 E4M3 byte
in_valid  input  1  in_data valid
in_ready  output  1  decoder can accept a byte
out_data  output  OUT_W  signed fixed-point value, FRAC_W fraction bits
out_ovf  output  1  result saturated
out_valid  output  1  out_data/out_ovf valid
out_ready  input  1  consumer accepts the result

Behaviour:
- Reset: clk and rst_n are the only clock and reset. Reset is synchronous and active-low, sampled on the rising edge of clk. After reset: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_ovf=0.
- rst_n low mid-operation:
  - Aborts the conversion; the next edge returns to the reset state.
  - A pending result is discarded.
- in_ready = (state==IDLE) & ena. It is registered-state only, with no combinational path from out_ready.
- Decode of an accepted byte:
  - exp==0: e_eff=1, sig={0,mant}.
  - exp!=0: e_eff=exp, sig={1,mant}.
  - Shift amount s = e_eff - 10 + FRAC_W. s>0 shifts left, s<0 shifts right with truncation (magnitude toward zero).
- FSM states:
  - IDLE: on in_valid&in_ready&ena, capture sign and mag=sig (zero-extended to OUT_W+8 bits). Load cnt=|s| and dir. Go to SHIFT.
  - SHIFT: while cnt!=0, shift mag one bit in dir and decrement cnt. When cnt==0, apply saturation and sign, register out_data/out_ovf, and go to OUT.
  - OUT: out_valid=1. out_data and out_ovf are held stable until out_ready. On out_valid&out_ready, go to IDLE next edge.
- Latency: accept on edge k gives out_valid high after edge k+|s|+1. Example: FRAC_W=4 gives |s| in 0..9.
- Throughput: one result per |s|+3 cycles minimum (IDLE, SHIFT, OUT).
- Saturation:
  - If the magnitude exceeds 2^(OUT_W-1)-1, out_data = +max (0x7FFF) or -2^(OUT_W-1) (0x8000) by sign, and out_ovf=1.
  - Otherwise out_ovf=0.
- Sign: negative results are the two's complement of the magnitude. Negative zero (0x80) and any magnitude truncated to 0 give out_data=0.
- NaN (exp=1111, mant=111, either sign): out_data=0 and out_ovf=0. Latency equals that of a normal conversion with s=0.
- ena low in any state: everything freezes and no handshake completes. in_ready=0 while ena=0.

Optional Feature:
FP8_NAN_FLAG_EN
- Defined: adds output port out_nan (1 bit, reset 0). It is registered together with out_data and is valid while out_valid=1. It is 1 exactly when the accepted byte was NaN; out_data=0 in that case.
- Undefined: no out_nan port. NaN decodes silently to 0 as described above.

Test Plan:
1. Reset with rst_n=0 for 3 edges -> in_ready=1, out_valid=0, out_data=0x0000. Then send 0x40 -> out_data=0x0020 (2.0), out_ovf=0, out_valid high 3 edges after accept.
2. Send 0xC4 -> 0xFFD0 (-3.0). Send 0x38 -> 0x0010 (1.0). Send 0x28 -> 0x0004 (0.25). Send 0x01 -> 0x0000 (truncated). Send 0x80 -> 0x0000.
3. Send 0x7E -> 0x1C00 (448.0), out_valid 10 edges after accept. With FRAC_W=7, 0x7E -> 0x7FFF with out_ovf=1 and 0xFE -> 0x8000 with out_ovf=1.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0, a new in_valid is not accepted. Raise out_ready -> handshake completes, in_ready=1 the next cycle.
5. Drop rst_n for one edge during SHIFT of 0x7E -> out_valid never asserts and state=IDLE. A following 0x40 decodes to 0x0020. Drop ena for 4 cycles mid-SHIFT -> latency extends by exactly 4 cycles and the result is unchanged.
6. Send 0x7F and 0xFF -> out_data=0; with FP8_NAN_FLAG_EN, out_nan=1. A following 0x40 gives out_nan=0.
